// File: rtl/vector_loader.sv
// Vector loader: gathers a stream of signed (x, w) element pairs into packed
// N-element vectors laid out for a dot-product unit. A short vector is closed
// early with in_last; its unwritten slots read zero so they do not change the
// dot product. A finished vector is held stable until the downstream consumes
// it, then every slot is cleared before the next vector starts filling.
module vector_loader #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = $clog2(N + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_x,
  input  logic signed [DATA_WIDTH-1:0] in_w,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [N*DATA_WIDTH-1:0] out_x,
  output logic signed [N*DATA_WIDTH-1:0] out_w,
  output logic [CNT_WIDTH-1:0]         out_count
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  // Fill index doubles as the element count of the vector being built.
  logic [CNT_WIDTH-1:0]          idx_p0;
  logic [CNT_WIDTH-1:0]          count_p0;
  logic signed [N*DATA_WIDTH-1:0] x_p0;
  logic signed [N*DATA_WIDTH-1:0] w_p0;

  logic accept;
  logic last_elem;
  logic release_vec;

  // Handshake decode from state only, plus next-state selection.
  always_comb begin
    state_d     = state_q;
    in_ready    = (state_q == FILL);
    out_valid   = (state_q == HOLD);
    accept      = in_ready && in_valid;
    last_elem   = accept && ((idx_p0 == CNT_WIDTH'(N - 1)) || in_last);
    release_vec = out_valid && out_ready;
    case (state_q)
      FILL: if (last_elem) state_d = HOLD;
      HOLD: if (out_ready) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Slot storage: write the accepted pair into slot idx; clear everything once
  // the held vector is consumed so no stale element survives into the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_p0   <= '0;
      count_p0 <= '0;
      x_p0     <= '0;
      w_p0     <= '0;
    end else if (release_vec) begin
      idx_p0   <= '0;
      count_p0 <= '0;
      x_p0     <= '0;
      w_p0     <= '0;
    end else if (accept) begin
      for (int i = 0; i < N; i++) begin
        if (idx_p0 == CNT_WIDTH'(i)) begin
          x_p0[i*DATA_WIDTH +: DATA_WIDTH] <= in_x;
          w_p0[i*DATA_WIDTH +: DATA_WIDTH] <= in_w;
        end
      end
      idx_p0 <= idx_p0 + 1'b1;
      if (last_elem) begin
        count_p0 <= idx_p0 + 1'b1;
      end
    end
  end

  assign out_x     = x_p0;
  assign out_w     = w_p0;
  assign out_count = count_p0;

endmodule

// File: tb/tb_vector_loader.sv
// Directed testbench for vector_loader (N=4, DATA_WIDTH=8).
module tb_vector_loader;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 3;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [DW-1:0]        in_x;
  logic [DW-1:0]        in_w;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [N*DW-1:0]      out_x;
  logic [N*DW-1:0]      out_w;
  logic [CW-1:0]        out_count;

  int n_cmp  = 0;
  int n_fail = 0;

  vector_loader #(.N(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_w      (in_w),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_w     (out_w),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          vld;
    logic [DW-1:0] x;
    logic [DW-1:0] w;
    logic          last;
    logic          rdy;
    logic          e_ov;
    logic          e_ir;
    logic [31:0]   e_x;
    logic [31:0]   e_w;
    logic [CW-1:0] e_c;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ov, input logic ir,
                         input logic [31:0] ex, input logic [31:0] ew, input logic [CW-1:0] ec);
    chk({tag, " out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, " in_ready"},  32'(in_ready),  32'(ir));
    chk({tag, " out_x"},     out_x,          ex);
    chk({tag, " out_w"},     out_w,          ew);
    chk({tag, " out_count"}, 32'(out_count), 32'(ec));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] x, input logic [DW-1:0] w,
                       input logic l, input logic r);
    in_valid  = v;
    in_x      = x;
    in_w      = w;
    in_last   = l;
    out_ready = r;
  endtask

  initial begin
    // Full vector, hold with junk on the input, release.
    tbl[0]  = '{1'b1, 8'h01, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000001, 32'h00000005, 3'd0};
    tbl[1]  = '{1'b1, 8'h02, 8'h06, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000201, 32'h00000605, 3'd0};
    tbl[2]  = '{1'b1, 8'h03, 8'h07, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00030201, 32'h00070605, 3'd0};
    tbl[3]  = '{1'b1, 8'h04, 8'h08, 1'b0, 1'b0, 1'b1, 1'b0, 32'h04030201, 32'h08070605, 3'd4};
    tbl[4]  = '{1'b1, 8'h09, 8'h09, 1'b0, 1'b0, 1'b1, 1'b0, 32'h04030201, 32'h08070605, 3'd4};
    tbl[5]  = '{1'b1, 8'h09, 8'h09, 1'b0, 1'b0, 1'b1, 1'b0, 32'h04030201, 32'h08070605, 3'd4};
    tbl[6]  = '{1'b1, 8'h09, 8'h09, 1'b0, 1'b0, 1'b1, 1'b0, 32'h04030201, 32'h08070605, 3'd4};
    tbl[7]  = '{1'b1, 8'h09, 8'h09, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00000000, 32'h00000000, 3'd0};
    // Short vector of two negative x values.
    tbl[8]  = '{1'b1, 8'hFF, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1, 32'h000000FF, 32'h00000003, 3'd0};
    tbl[9]  = '{1'b1, 8'hFE, 8'h04, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000FEFF, 32'h00000403, 3'd2};
    tbl[10] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00000000, 32'h00000000, 3'd0};
    // Single-element vector closed on the first element.
    tbl[11] = '{1'b1, 8'h07, 8'hFD, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00000007, 32'h000000FD, 3'd1};
    tbl[12] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00000000, 32'h00000000, 3'd0};
    // in_last together with the final slot behaves as a plain full vector.
    tbl[13] = '{1'b1, 8'h11, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000011, 32'h00000012, 3'd0};
    tbl[14] = '{1'b1, 8'h22, 8'h23, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00002211, 32'h00002312, 3'd0};
    tbl[15] = '{1'b1, 8'h33, 8'h34, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00332211, 32'h00342312, 3'd0};
    tbl[16] = '{1'b1, 8'h44, 8'h45, 1'b1, 1'b0, 1'b1, 1'b0, 32'h44332211, 32'h45342312, 3'd4};
    tbl[17] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00000000, 32'h00000000, 3'd0};
    // Short vector after a full one: upper slots must be zero, not stale.
    tbl[18] = '{1'b1, 8'h55, 8'h66, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00000055, 32'h00000066, 3'd1};
    tbl[19] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00000000, 32'h00000000, 3'd0};

    drive(1'b0, '0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #12;
    chk_all("reset", 1'b0, 1'b1, 32'h0, 32'h0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].vld, tbl[i].x, tbl[i].w, tbl[i].last, tbl[i].rdy);
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].e_ov, tbl[i].e_ir, tbl[i].e_x, tbl[i].e_w, tbl[i].e_c);
    end

    // Reset in the middle of filling discards the partial vector.
    drive(1'b1, 8'hAA, 8'hBA, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'hBB, 8'hBC, 1'b0, 1'b0);
    tick();
    rst_n = 1'b0;
    #2;
    chk_all("rst_fill", 1'b0, 1'b1, 32'h0, 32'h0, 3'd0);
    drive(1'b1, 8'd10, 8'd20, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_all("post_rst0", 1'b0, 1'b1, 32'h0000000A, 32'h00000014, 3'd0);
    for (int k = 1; k < 4; k++) begin
      drive(1'b1, 8'(10 + k), 8'(20 + k), 1'b0, 1'b0);
      tick();
    end
    chk_all("post_rst_vec", 1'b1, 1'b0, 32'h0D0C0B0A, 32'h17161514, 3'd4);

    // Reset while holding drops the pending vector without a transfer.
    rst_n = 1'b0;
    #2;
    chk_all("rst_hold", 1'b0, 1'b1, 32'h0, 32'h0, 3'd0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_all("rst_hold_after", 1'b0, 1'b1, 32'h0, 32'h0, 3'd0);

    // Streaming: both sides always ready; a vector every N+1 cycles.
    begin
      int k;
      int nvec;
      logic [31:0] ex;
      logic [31:0] ew;
      k    = 1;
      nvec = 0;
      for (int c = 0; c < 20; c++) begin
        if ((c % 5) != 4) begin
          drive(1'b1, 8'(k), 8'(k + 100), 1'b0, 1'b1);
          k++;
        end else begin
          drive(1'b1, 8'h7F, 8'h7F, 1'b0, 1'b1);
        end
        tick();
        chk($sformatf("stream ov c%0d", c), 32'(out_valid), 32'((c % 5) == 3));
        if ((c % 5) == 3) begin
          ex = {8'(4*nvec + 4), 8'(4*nvec + 3), 8'(4*nvec + 2), 8'(4*nvec + 1)};
          ew = {8'(4*nvec + 104), 8'(4*nvec + 103), 8'(4*nvec + 102), 8'(4*nvec + 101)};
          chk($sformatf("stream x v%0d", nvec), out_x, ex);
          chk($sformatf("stream w v%0d", nvec), out_w, ew);
          chk($sformatf("stream cnt v%0d", nvec), 32'(out_count), 32'd4);
        end
        if (out_valid) nvec++;
      end
      chk("stream vectors", 32'(nvec), 32'd4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_loader.md
VECTOR_LOADER -- requirements
Module: vector_loader

Interface
REQ-001 SHALL have parameter N, default `N, vector length in elements, N >= 1.
REQ-002 SHALL have parameter DATA_WIDTH, default `DATA_WIDTH, signed element width.
REQ-003 SHALL have parameter CNT_WIDTH, default $clog2(N+1), width of out_count.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  element pair present.
REQ-007 SHALL have port in_ready  output  1  loader accepts element pair.
REQ-008 SHALL have port in_x  input  DATA_WIDTH  signed x element.
REQ-009 SHALL have port in_w  input  DATA_WIDTH  signed w element.
REQ-010 SHALL have port in_last  input  1  final element of a short vector; sampled with in_valid.
REQ-011 SHALL have port out_valid  output  1  packed vector pair available.
REQ-012 SHALL have port out_ready  input  1  downstream consumes vector pair.
REQ-013 SHALL have port out_x  output  N*DATA_WIDTH  packed signed x vector, dot-product layout.
REQ-014 SHALL have port out_w  output  N*DATA_WIDTH  packed signed w vector, dot-product layout.
REQ-015 SHALL have port out_count  output  CNT_WIDTH  number of valid elements in the vector, 1..N.

Function
REQ-016 Transfer SHALL occur on a rising clk edge with valid and ready both high, on each side independently.
REQ-017 SHALL implement two states: FILL (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-018 Element accepted in FILL SHALL be written to slot idx: out_x[idx*DATA_WIDTH +: DATA_WIDTH]=in_x, same for out_w; idx then increments.
REQ-019 FILL->HOLD SHALL occur on acceptance when idx==N-1 or in_last==1; out_count = idx+1 at that edge.
REQ-020 in_last with idx==N-1 SHALL behave identically to a normal full vector.
REQ-021 Slots not written in the current vector SHALL read zero (zero-pad, dot-product neutral).
REQ-022 HOLD->FILL SHALL occur on out_ready==1; idx<=0, all slots cleared to zero, out_count<=0.
REQ-023 out_x, out_w, out_count SHALL be stable throughout HOLD while out_ready==0.
REQ-024 in_valid in HOLD SHALL be ignored; in_x/in_w/in_last SHALL NOT be sampled.
REQ-025 in_ready and out_valid SHALL be decoded from state only, no combinational path from in_valid or out_ready.
REQ-026 Latency: out_valid SHALL rise in the cycle after the final element is accepted.
REQ-027 Peak throughput SHALL be one N-element vector per N+1 cycles.
REQ-028 out_x/out_w SHALL never contain data from a previous vector.

Reset
REQ-029 rst_n low SHALL asynchronously force state=FILL, idx=0, all slots 0, out_count=0, out_valid=0, in_ready=1.
REQ-030 Reset mid-FILL or mid-HOLD SHALL discard the partial/pending vector with no output transfer.
REQ-031 Deassertion SHALL be honoured at the next rising clk edge; first acceptance possible at that edge.

Verification (N=4, DATA_WIDTH=8)
REQ-032 Pairs x=1,2,3,4 w=5,6,7,8 back-to-back, out_ready=0 -> next cycle out_valid=1, out_x=0x04030201, out_w=0x08070605, out_count=4, in_ready=0.
REQ-033 Hold out_ready=0 for 3 cycles with in_valid=1, in_x=9 -> outputs unchanged, no acceptance; out_ready=1 -> next cycle in_ready=1, out_x=0.
REQ-034 x=-1,-2 w=3,4, in_last on 2nd -> out_x=0x0000FEFF, out_w=0x00000403, out_count=2.
REQ-035 in_last on 1st element x=7 w=-3 -> out_x=0x00000007, out_w=0x000000FD, out_count=1.
REQ-036 Reset pulse after 2 accepted elements, then 4 fresh pairs x=10..13 -> out_x=0x0D0C0B0A, out_count=4, no stale slot.
REQ-037 out_ready=1 and in_valid=1 constant for 20 cycles -> out_valid high every 5th cycle, 4 vectors delivered, elements in order.
